// File: rtl/gauss_periph_if.sv
// Gauss filter register window (CTRL/STATUS/DATA_IN/DATA_OUT) with start/done handshake and watchdog; irq_o under GAUSS_IRQ_EN.
// Latency: read data 1 cycle after rd_en_i; filt_start_o 1 cycle after the CTRL start write.
// Backpressure: none; every bus access completes in a single cycle.
module gauss_periph_if #(
    parameter int          DATA_W      = 32,
    parameter logic [31:0] MATCH_MASK  = 32'h0000_F0F0,
    parameter logic [31:0] MATCH_VAL   = 32'h0000_2030,
    parameter int          TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       addr_i,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              select_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o,
    output logic              filt_start_o,
    output logic [DATA_W-1:0] filt_din_o,
`ifdef GAUSS_IRQ_EN
    output logic              irq_o,
`endif
    input  logic              filt_done_i,
    input  logic [DATA_W-1:0] filt_dout_i
);

    localparam int                CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYC);
    localparam logic [1:0] OFF_CTRL    = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_DATA_IN = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;
    logic               r_timeout;
    logic               r_ie;
    logic [DATA_W-1:0]  r_din;
    logic [DATA_W-1:0]  r_dout;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_rvalid;
    logic               r_start;

    logic               w_rd;
    logic               w_wr;
    logic [1:0]         w_off;
    logic               w_busy;
    logic               w_start_req;
    logic               w_rd_status;
    logic               w_go;
    logic               w_done_hit;
    logic               w_to_hit;
    logic [DATA_W-1:0]  w_rdata_nxt;

    assign select_o     = ((addr_i & MATCH_MASK) == MATCH_VAL);
    assign w_off        = addr_i[3:2];
    assign w_rd         = rd_en_i & select_o;
    assign w_wr         = wr_en_i & select_o;
    assign w_busy       = (r_state == S_BUSY);
    assign w_start_req  = w_wr && (w_off == OFF_CTRL) && wdata_i[0];
    assign w_rd_status  = w_rd && (w_off == OFF_STATUS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Done beats the watchdog when both land on the final BUSY cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_go        = 1'b0;
        w_done_hit  = 1'b0;
        w_to_hit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_req) begin
                    w_state_nxt = S_BUSY;
                    w_go        = 1'b1;
                end
            end
            S_BUSY: begin
                if (filt_done_i) begin
                    w_state_nxt = S_DONE;
                    w_done_hit  = 1'b1;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = S_IDLE;
                    w_to_hit    = 1'b1;
                end
            end
            S_DONE: begin
                if (w_start_req) begin
                    w_state_nxt = S_BUSY;
                    w_go        = 1'b1;
                end else if (w_rd_status) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdata_nxt = '0;
        case (w_off)
            OFF_CTRL:    w_rdata_nxt[1]   = r_ie;
            OFF_STATUS:  w_rdata_nxt[2:0] = {r_timeout, r_done, w_busy};
            OFF_DATA_IN: w_rdata_nxt      = r_din;
            default:     w_rdata_nxt      = r_dout;
        endcase
    end

    // A set event outranks a coincident read-to-clear; the read still returns the old flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_ie      <= 1'b0;
            r_din     <= '0;
            r_dout    <= '0;
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
            r_start   <= 1'b0;
        end else begin
            r_start  <= w_go;
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rdata_nxt;
            end
            if (w_go) begin
                r_cnt <= '0;
            end else if (w_busy) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_go) begin
                r_done <= 1'b0;
            end else if (w_done_hit) begin
                r_done <= 1'b1;
            end else if (w_rd_status) begin
                r_done <= 1'b0;
            end
            if (w_go) begin
                r_timeout <= 1'b0;
            end else if (w_to_hit) begin
                r_timeout <= 1'b1;
            end else if (w_rd_status) begin
                r_timeout <= 1'b0;
            end
            if (w_wr && (w_off == OFF_CTRL)) begin
                r_ie <= wdata_i[1];
            end
            if (w_wr && (w_off == OFF_DATA_IN) && !w_busy) begin
                r_din <= wdata_i;
            end
            if (w_done_hit) begin
                r_dout <= filt_dout_i;
            end
        end
    end

    assign rdata_o      = r_rdata;
    assign rvalid_o     = r_rvalid;
    assign filt_start_o = r_start;
    assign filt_din_o   = r_din;
`ifdef GAUSS_IRQ_EN
    assign irq_o        = r_ie & (r_done | r_timeout);
`endif

endmodule
